// File: rtl/sram_bus_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sram_bus_ctrl : shared-bus slave driving one single-port GF180 SRAM macro
// Rev 1.0
// ---------------------------------------------------------------------------
module sram_bus_ctrl #(
  parameter int          NUM_WORDS    = 512,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          READ_LATENCY = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [31:0]                  mem_addr,
  input  logic [31:0]                  mem_wdata,
  input  logic [3:0]                   mem_wmask,
  input  logic                         mem_wstrb,
  input  logic                         mem_rstrb,
  output logic [31:0]                  mem_rdata,
  output logic                         mem_done,
  output logic                         bus_err,
  output logic                         sram_cen_n,
  output logic                         sram_gwen_n,
  output logic [31:0]                  sram_wen_n,
  output logic [$clog2(NUM_WORDS)-1:0] sram_addr,
  output logic [31:0]                  sram_d,
  input  logic [31:0]                  sram_q
);

  localparam int          AW       = $clog2(NUM_WORDS);
  localparam logic [31:0] OFS_MASK = 32'(NUM_WORDS * 4 - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          rd_op_q, rd_op_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          cen_n_q, cen_n_d;
  logic          gwen_n_q, gwen_n_d;
  logic [31:0]   wen_n_q, wen_n_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   d_q, d_d;
  logic          hit;

  always_comb begin
    hit      = (mem_addr & ~OFS_MASK) == BASE_ADDR;
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_op_d  = rd_op_q;
    rdata_d  = rdata_q;
    addr_d   = addr_q;
    d_d      = d_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    cen_n_d  = 1'b1;
    gwen_n_d = 1'b1;
    wen_n_d  = '1;
    case (state_q)
      S_IDLE: begin
        // A write takes priority when both strobes are raised together.
        if (mem_wstrb) begin
          rd_op_d = 1'b0;
          if (hit) begin
            state_d = S_ACCESS;
            if (|mem_wmask) begin
              cen_n_d  = 1'b0;
              gwen_n_d = 1'b0;
              addr_d   = mem_addr[AW+1:2];
              d_d      = mem_wdata;
              for (int i = 0; i < 4; i++) begin
                wen_n_d[8*i +: 8] = {8{~mem_wmask[i]}};
              end
            end
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end
        end else if (mem_rstrb) begin
          rd_op_d = 1'b1;
          if (hit) begin
            state_d = S_ACCESS;
            cen_n_d = 1'b0;
            addr_d  = mem_addr[AW+1:2];
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end
      S_ACCESS: begin
        if (rd_op_q) begin
          state_d = S_WAIT;
          cnt_d   = 3'(READ_LATENCY - 1);
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_WAIT: begin
        // Last wait cycle is the one in which the macro output is valid.
        if (cnt_q == 3'd0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          rdata_d = sram_q;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      cnt_q    <= 3'd0;
      rd_op_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      cen_n_q  <= 1'b1;
      gwen_n_q <= 1'b1;
      wen_n_q  <= '1;
      addr_q   <= '0;
      d_q      <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_op_q  <= rd_op_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      cen_n_q  <= cen_n_d;
      gwen_n_q <= gwen_n_d;
      wen_n_q  <= wen_n_d;
      addr_q   <= addr_d;
      d_q      <= d_d;
    end
  end

  assign mem_rdata   = rdata_q;
  assign mem_done    = done_q;
  assign bus_err     = err_q;
  assign sram_cen_n  = cen_n_q;
  assign sram_gwen_n = gwen_n_q;
  assign sram_wen_n  = wen_n_q;
  assign sram_addr   = addr_q;
  assign sram_d      = d_q;

endmodule
`default_nettype wire
